// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU memory-side blocks
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_ctrl_state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/mem_data_ctrl.sv
// mem_data_ctrl: sequences one MEM-stage load/store onto the SRAM-like data bus.
//   clk, rst (async, active-low)
//   req_valid/req_wr/req_size/req_addr/req_wdata : access from MEM
//   flush, pipe_stall                             : pipeline control
//   mem_stall, rdata_o                            : stall and held load data to MEM
//   data_req/wr/size/addr/wdata -> bus, data_rdata/addr_ok/data_ok <- bus
module mem_data_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  input  logic              pipe_stall,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);
  mem_ctrl_state_t state, state_n;
  logic cancel_q, cancel_n;
  logic accept, retire, kill, capture;
  always_comb begin
    accept    = state == IDLE && req_valid && !flush;
    retire    = (state == REQ && data_addr_ok && data_data_ok) || (state == WAIT && data_data_ok);
    kill      = cancel_q || flush;
    // a flushed transaction still drains on the bus, but its data is dropped
    capture   = retire && !data_wr && !kill;
    mem_stall = req_valid && !flush && !(state == DONE && !cancel_q);
    state_n   = state;
    case (state)
      IDLE:    state_n = accept ? REQ : IDLE;
      REQ:     state_n = data_addr_ok ? (data_data_ok ? (kill ? IDLE : DONE) : WAIT) : REQ;
      WAIT:    state_n = data_data_ok ? (kill ? IDLE : DONE) : WAIT;
      default: state_n = (pipe_stall && !flush) ? DONE : IDLE;
    endcase
    cancel_n = (state_n == IDLE) ? 1'b0 : cancel_q || (flush && (state == REQ || state == WAIT));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cancel_q   <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
      rdata_o    <= '0;
    end else begin
      state    <= state_n;
      cancel_q <= cancel_n;
      // request stays up until the address phase is accepted, flush or not
      data_req <= state_n == REQ;
      if (accept) begin
        data_wr    <= req_wr;
        data_size  <= req_size;
        data_addr  <= req_addr;
        data_wdata <= req_wdata;
      end
      if (capture) rdata_o <= data_rdata;
    end
  end
endmodule

// File: tb/tb_mem_data_ctrl.sv
// tb_mem_data_ctrl: directed self-checking bench for mem_data_ctrl
module tb_mem_data_ctrl;
  import cpu_pkg::*;
  logic        clk = 0, rst = 0;
  logic        req_valid = 0, req_wr = 0, flush = 0, pipe_stall = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        mem_stall, data_req, data_wr;
  logic [31:0] rdata_o, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [31:0] data_rdata = 0;
  logic        data_addr_ok = 0, data_data_ok = 0;
  int          n_run = 0, n_fail = 0, req_hi = 0, base;

  mem_data_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .pipe_stall(pipe_stall),
    .mem_stall(mem_stall), .rdata_o(rdata_o), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (data_req) req_hi <= req_hi + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
  endtask

  initial begin
    cyc; cyc;
    check("rst_req", {31'b0, data_req}, 0);
    check("rst_stall", {31'b0, mem_stall}, 0);
    check("rst_bus", {data_addr | data_wdata | {29'b0, data_wr, data_size}}, 0);
    check("rst_rdata", rdata_o, 0);
    rst = 1;
    cyc;
    // 1: load word, zero-wait bus
    base = req_hi;
    set_req(0, SIZE_WORD, 32'h0000_1004, 0); #1;
    check("t1_stall_t", {31'b0, mem_stall}, 1);
    check("t1_req_t", {31'b0, data_req}, 0);
    cyc; bus(1, 1, 32'hDEAD_BEEF); #1;
    check("t1_req_t1", {31'b0, data_req}, 1);
    check("t1_addr", data_addr, 32'h0000_1004);
    check("t1_size", {30'b0, data_size}, SIZE_WORD);
    check("t1_stall_t1", {31'b0, mem_stall}, 1);
    cyc; bus(0, 0, 0); #1;
    check("t1_stall_done", {31'b0, mem_stall}, 0);
    check("t1_rdata", rdata_o, 32'hDEAD_BEEF);
    check("t1_req_done", {31'b0, data_req}, 0);
    req_valid = 0;
    cyc;
    check("t1_req_count", req_hi - base, 1);
    // 2: store byte, addr_ok on 3rd REQ cycle, data_ok 2 cycles later
    set_req(1, SIZE_BYTE, 32'h0000_2003, 32'h5A5A_5A5A); #1;
    check("t2_stall_t", {31'b0, mem_stall}, 1);
    for (int i = 0; i < 3; i++) begin
      cyc;
      if (i == 2) bus(1, 0, 0);
      #1;
      check("t2_req", {31'b0, data_req}, 1);
      check("t2_addr", data_addr, 32'h0000_2003);
      check("t2_wr", {31'b0, data_wr}, 1);
      check("t2_size", {30'b0, data_size}, SIZE_BYTE);
      check("t2_wdata", data_wdata, 32'h5A5A_5A5A);
      check("t2_stall_req", {31'b0, mem_stall}, 1);
    end
    cyc; bus(0, 0, 0); #1;
    check("t2_req_wait", {31'b0, data_req}, 0);
    check("t2_stall_wait1", {31'b0, mem_stall}, 1);
    cyc; bus(0, 1, 32'hBAD0_BAD0); #1;
    check("t2_stall_wait2", {31'b0, mem_stall}, 1);
    check("t2_addr_wait", data_addr, 32'h0000_2003);
    cyc; bus(0, 0, 0); #1;
    check("t2_stall_done", {31'b0, mem_stall}, 0);
    check("t2_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    req_valid = 0;
    cyc;
    // 3: flush in REQ before addr_ok
    set_req(0, SIZE_WORD, 32'h0000_3000, 0); #1;
    cyc; flush = 1; #1;
    check("t3_stall_flush", {31'b0, mem_stall}, 0);
    check("t3_req_flush", {31'b0, data_req}, 1);
    cyc; flush = 0; req_valid = 0; #1;
    check("t3_req_held", {31'b0, data_req}, 1);
    bus(1, 0, 0);
    cyc; bus(0, 1, 32'h1111_1111); #1;
    check("t3_req_wait", {31'b0, data_req}, 0);
    cyc; bus(0, 0, 0); #1;
    check("t3_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    check("t3_stall_idle", {31'b0, mem_stall}, 0);
    set_req(0, SIZE_WORD, 32'h0000_3004, 0); #1;
    check("t3_idle_accept", {31'b0, mem_stall}, 1);
    cyc; bus(1, 1, 32'h2222_2222); #1;
    check("t3_req_next", {31'b0, data_req}, 1);
    check("t3_addr_next", data_addr, 32'h0000_3004);
    cyc; bus(0, 0, 0); #1;
    check("t3_rdata_next", rdata_o, 32'h2222_2222);
    req_valid = 0;
    cyc;
    // 4: completion under pipe_stall for 4 cycles
    base = req_hi;
    pipe_stall = 1;
    set_req(0, SIZE_WORD, 32'h0000_4000, 0);
    cyc; bus(1, 1, 32'hCAFE_F00D);
    cyc; bus(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pipe_stall = 0;
      #1;
      check("t4_stall_done", {31'b0, mem_stall}, 0);
      check("t4_req_done", {31'b0, data_req}, 0);
      check("t4_rdata_held", rdata_o, 32'hCAFE_F00D);
      cyc;
    end
    req_valid = 0; #1;
    check("t4_req_idle", {31'b0, data_req}, 0);
    cyc;
    check("t4_no_reissue", {31'b0, data_req}, 0);
    check("t4_req_count", req_hi - base, 1);
    // 5: back-to-back loads
    set_req(0, SIZE_WORD, 32'h0000_0010, 0);
    cyc; bus(1, 1, 32'h0000_1010);
    cyc; bus(0, 0, 0); #1;
    check("t5_rdata1", rdata_o, 32'h0000_1010);
    check("t5_stall_done1", {31'b0, mem_stall}, 0);
    cyc; set_req(0, SIZE_WORD, 32'h0000_0014, 0); #1;
    check("t5_stall_accept2", {31'b0, mem_stall}, 1);
    check("t5_req_idle", {31'b0, data_req}, 0);
    cyc; bus(1, 1, 32'h0000_1414); #1;
    check("t5_req2", {31'b0, data_req}, 1);
    check("t5_addr2", data_addr, 32'h0000_0014);
    cyc; bus(0, 0, 0); #1;
    check("t5_rdata2", rdata_o, 32'h0000_1414);
    req_valid = 0;
    cyc;
    // 6: async reset while in WAIT
    set_req(1, SIZE_WORD, 32'h0000_5000, 32'h1234_5678);
    cyc; bus(1, 0, 0);
    cyc; bus(0, 0, 0); #1;
    check("t6_req_wait", {31'b0, data_req}, 0);
    check("t6_stall_wait", {31'b0, mem_stall}, 1);
    #1; rst = 0; req_valid = 0; #1;
    check("t6_rst_addr", data_addr, 0);
    check("t6_rst_wdata", data_wdata, 0);
    check("t6_rst_ctl", {29'b0, data_wr, data_size}, 0);
    check("t6_rst_rdata", rdata_o, 0);
    check("t6_rst_stall", {31'b0, mem_stall}, 0);
    cyc; rst = 1;
    cyc; set_req(0, SIZE_WORD, 32'h0000_6000, 0); #1;
    check("t6_stall_restart", {31'b0, mem_stall}, 1);
    cyc; bus(1, 1, 32'h6666_6666); #1;
    check("t6_req_restart", {31'b0, data_req}, 1);
    check("t6_addr_restart", data_addr, 32'h0000_6000);
    cyc; bus(0, 0, 0); #1;
    check("t6_rdata_restart", rdata_o, 32'h6666_6666);
    check("t6_stall_done", {31'b0, mem_stall}, 0);
    req_valid = 0;
    cyc;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
